usb_crc5_serial: RTL and testbench
==================================

Name: usb_crc5_serial

Overview:
- Serial USB CRC5 generator for token packets.
- Consumes an MSB-first serial bit stream while a start strobe is held high, then emits the 5-bit complemented CRC serially with a ready/done handshake.
- Sits between the token field serializer and the NRZI/bit-stuff stage; a downstream serial-in/parallel-out register may capture the CRC bits.

Parameters:
- POLY, 5'b00101, low 5 terms of generator x^5+x^2+1.
- INIT, 5'b11111, remainder preset value.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-high reset (asserted = 1), sampled on the rising edge of clk.
- crc5_start  input  1  high while the data field is streamed; falling edge ends the data field.
- s_in  input  1  serial data bit, one per clock.
- crc5_out  output  1  serial CRC bit, valid while crc5_ready=1.
- crc5_ready  output  1  high for exactly 5 cycles while CRC bits are presented.
- crc5_done  output  1  one-cycle pulse after the last CRC bit.

Behaviour:
- All outputs and state are registered.
- Reset (rst_n=1 at a clock edge):
  - state=IDLE, rem=INIT, bit counter=0.
  - crc5_out=0, crc5_ready=0, crc5_done=0.
  - Reset overrides everything, including mid-CALC or mid-SEND; no partial CRC is emitted afterwards.
- LFSR step on a bit b: fb = rem[4]^b; rem = {rem[3:0],1'b0} ^ (fb ? POLY : 0).
- States: IDLE, CALC, SEND, DONE.
- IDLE:
  - Outputs 0.
  - crc5_start=1 loads rem=INIT, goes to CALC, and does not sample s_in (arming cycle).
  - Otherwise stays in IDLE.
- CALC:
  - crc5_start=1: apply one LFSR step with s_in; stay in CALC.
  - crc5_start=0: s_in ignored; latch ~rem into the output shift register; counter=0; go to SEND.
  - No limit on field length; 11 bits is the USB token case.
  - Zero data bits (start high for only the arming cycle) is legal and yields CRC 00000.
- SEND:
  - crc5_ready=1.
  - crc5_out = output shift register MSB, i.e. ~rem[4] first, then ~rem[3] … ~rem[0].
  - Shift one bit per cycle; exactly 5 cycles, then go to DONE.
  - crc5_start and s_in are ignored.
- DONE:
  - crc5_done=1, crc5_ready=0, crc5_out=0 for one cycle, then IDLE.
  - crc5_start is ignored in this cycle; a new packet must present its arming cycle in IDLE.
- Latency: the first CRC bit appears on the first edge after crc5_start is sampled low. crc5_done rises 5 cycles after crc5_ready rises.
- crc5_ready and crc5_done are never high together.

Test Plan:
- Reset behaviour: hold rst_n=1 for 2 cycles, with crc5_start=1 driven during reset -> all outputs 0; FSM stays IDLE until rst_n=0 and then arms on the next start-high cycle.
- Token stream: one arming cycle, then 11 bits 0,0,0,0,1,0,0,0,1,1,1 with crc5_start=1, then drop start.
  - crc5_ready high for 5 cycles; crc5_out = 1,0,1,0,0 (remainder 01011, complemented).
  - SIPO-captured value 10100; crc5_done pulses once.
- All-zero token: arming cycle plus 11 zero bits -> crc5_out = 0,1,0,0,0 (remainder 10111).
- Empty field: start high for arming cycle only -> crc5_out = 0,0,0,0,0, then a done pulse.
- Residual check: stream 00001000111 followed by 10100 (16 bits) -> internal remainder 01100; crc5_out = 1,0,0,1,1.
- Mid-operation reset:
  - Assert rst_n=1 during the 3rd SEND cycle -> crc5_ready falls at that edge; no done pulse.
  - A following full token packet produces the correct CRC.
  - Back-to-back packets: re-arm in the IDLE cycle right after crc5_done.

Source files
------------

// File: rtl/usb_crc5_serial.sv
// usb_crc5_serial: serial USB token CRC5 generator with ready/done handshake
module usb_crc5_serial #(
  parameter logic [4:0] POLY = 5'b00101,
  parameter logic [4:0] INIT = 5'b11111
) (
  input  logic clk,
  input  logic rst_n,
  input  logic crc5_start,
  input  logic s_in,
  output logic crc5_out,
  output logic crc5_ready,
  output logic crc5_done
);
  typedef enum logic [1:0] {IDLE, CALC, SEND, DONE} state_t;
  state_t state;
  logic [4:0] rem;
  logic [4:0] sh;
  logic [2:0] cnt;
  logic fb;
  assign fb = rem[4] ^ s_in;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      rem        <= INIT;
      sh         <= '0;
      cnt        <= '0;
      crc5_out   <= 1'b0;
      crc5_ready <= 1'b0;
      crc5_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          crc5_out   <= 1'b0;
          crc5_ready <= 1'b0;
          crc5_done  <= 1'b0;
          if (crc5_start) begin
            rem   <= INIT;
            state <= CALC;
          end
        end
        CALC: begin
          if (crc5_start) begin
            rem <= {rem[3:0], 1'b0} ^ (fb ? POLY : 5'b0);
          end else begin
            // MSB goes out immediately; the shifter holds the remaining four bits
            crc5_out   <= ~rem[4];
            sh         <= {~rem[3:0], 1'b0};
            crc5_ready <= 1'b1;
            cnt        <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (cnt == 3'd4) begin
            crc5_out   <= 1'b0;
            crc5_ready <= 1'b0;
            crc5_done  <= 1'b1;
            state      <= DONE;
          end else begin
            crc5_out <= sh[4];
            sh       <= {sh[3:0], 1'b0};
            cnt      <= cnt + 3'd1;
          end
        end
        DONE: begin
          crc5_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_crc5_serial.sv
// tb_usb_crc5_serial: randomized and directed checks against a polynomial-division model
module tb_usb_crc5_serial;
  localparam logic [4:0] INIT = 5'b11111;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic crc5_start = 1'b0;
  logic s_in = 1'b0;
  logic crc5_out, crc5_ready, crc5_done;
  int tests = 0;
  int fails = 0;

  usb_crc5_serial dut (
    .clk(clk), .rst_n(rst_n), .crc5_start(crc5_start), .s_in(s_in),
    .crc5_out(crc5_out), .crc5_ready(crc5_ready), .crc5_done(crc5_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC as (INIT*x^n + M*x^5) mod (x^5+x^2+1), complemented
  function automatic logic [4:0] model_crc(input logic [31:0] d, input int n);
    longint unsigned v;
    longint unsigned g;
    v = (longint'(INIT) << n) ^ (longint'(d) << 5);
    for (int b = n + 4; b >= 5; b--) begin
      g = 64'h25 << (b - 5);
      if (v[b]) v = v ^ g;
    end
    return ~v[4:0];
  endfunction

  task automatic send_packet(input logic [31:0] d, input int n,
                             output logic [4:0] got, output int ready_cnt,
                             output logic both_hi, output logic done_now,
                             output logic done_after);
    got = '0;
    ready_cnt = 0;
    both_hi = 1'b0;
    crc5_start = 1'b1;
    s_in = 1'($urandom);
    tick();
    for (int i = 0; i < n; i++) begin
      s_in = d[n-1-i];
      tick();
    end
    crc5_start = 1'b0;
    s_in = 1'($urandom);
    tick();
    for (int k = 0; k < 5; k++) begin
      got = {got[3:0], crc5_out};
      ready_cnt += int'(crc5_ready);
      both_hi |= crc5_ready & crc5_done;
      s_in = 1'($urandom);
      tick();
    end
    done_now = crc5_done & ~crc5_ready & ~crc5_out;
    tick();
    done_after = crc5_done | crc5_ready;
  endtask

  task automatic check_packet(input string name, input logic [31:0] d, input int n,
                              input logic [4:0] exp);
    logic [4:0] got;
    int rc;
    logic bh, dn, da;
    send_packet(d, n, got, rc, bh, dn, da);
    tests++;
    if (got !== exp || rc != 5 || bh !== 1'b0 || dn !== 1'b1 || da !== 1'b0) begin
      fails++;
      $display("FAIL %s: crc=%b ready_cycles=%0d both=%b done=%b after=%b, required crc=%b ready_cycles=5 both=0 done=1 after=0",
               name, got, rc, bh, dn, da, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    crc5_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if ({crc5_out, crc5_ready, crc5_done} !== 3'b000) begin
        fails++;
        $display("FAIL reset_outputs: got %b required 000", {crc5_out, crc5_ready, crc5_done});
      end
    end
    rst_n = 1'b0;
    crc5_start = 1'b0;
    tick();
    tests++;
    if ({crc5_out, crc5_ready, crc5_done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: got %b required 000", {crc5_out, crc5_ready, crc5_done});
    end
    check_packet("after_reset_token", 32'b00001000111, 11, 5'b10100);
  endtask

  task automatic test_vectors();
    check_packet("token", 32'b00001000111, 11, 5'b10100);
    check_packet("all_zero", 32'b0, 11, 5'b01000);
    check_packet("empty", 32'b0, 0, 5'b00000);
    check_packet("residual", 32'b0000100011110100, 16, 5'b10011);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int n;
      logic [31:0] d;
      n = int'($urandom_range(0, 20));
      d = $urandom & ((32'd1 << n) - 32'd1);
      check_packet($sformatf("random_n%0d", n), d, n, model_crc(d, n));
    end
  endtask

  task automatic test_mid_reset();
    logic seen;
    crc5_start = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      s_in = 1'($urandom);
      tick();
    end
    crc5_start = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if (crc5_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_in_send: ready=%b required 1", crc5_ready);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if ({crc5_ready, crc5_done} !== 2'b00) begin
      fails++;
      $display("FAIL mid_reset_abort: ready,done=%b required 00", {crc5_ready, crc5_done});
    end
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= crc5_ready | crc5_done | crc5_out;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_no_residue: activity=%b required 0", seen);
    end
    check_packet("post_reset_token", 32'b00001000111, 11, 5'b10100);
  endtask

  task automatic test_back_to_back();
    check_packet("b2b_first", 32'b00001000111, 11, 5'b10100);
    check_packet("b2b_second", 32'b0, 11, 5'b01000);
    check_packet("b2b_third", 32'h5A5, 11, model_crc(32'h5A5, 11));
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
